// File: rtl/core_pkg.sv
// Shared core types: ALU opcode constants, operand selects, EX bundle payload
// and the operand-order helper used by the issue stage.
package core_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned OP_WIDTH       = 5;

  localparam logic [OP_WIDTH-1:0] ADD_SUB = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] AND     = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OR      = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] XOR     = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] SLL     = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] SLT     = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] SLTU    = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] SRL_SRA = OP_WIDTH'(7);

  typedef enum logic [1:0] {
    OPA_RS1  = 2'd0,
    OPA_PC   = 2'd1,
    OPA_ZERO = 2'd2
  } op_a_sel_e;

  typedef enum logic [1:0] {
    OPB_RS2 = 2'd0,
    OPB_IMM = 2'd1,
    OPB_4   = 2'd2
  } op_b_sel_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     op_a;
    logic [DATA_WIDTH-1:0]     op_b;
    logic [OP_WIDTH-1:0]       alu_op;
    logic                      invert;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_we;
  } ex_bundle_t;

  // Shifts and compares take data/left comparand on B, amount/right comparand on A.
  function automatic logic needs_swap(input logic [OP_WIDTH-1:0] op);
    return (op == SLL) || (op == SRL_SRA) || (op == SLT) || (op == SLTU);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Resolves one source register through EX and WB bypasses; also flags a
// read of the register currently being produced in EX.
module fwd_mux
  import core_pkg::*;
#(
  parameter bit EX_BYPASS = 1'b1
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic                      rs_use,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      ex_we,
  input  logic [REG_ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0]     ex_data,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic [DATA_WIDTH-1:0]     rs_data,
  output logic                      ex_conflict
);

  logic rs_zero;
  logic ex_hit;
  logic wb_hit;

  assign rs_zero     = (rs_addr == '0);
  assign ex_hit      = ex_we && (ex_addr == rs_addr) && !rs_zero;
  assign wb_hit      = wb_we && (wb_addr == rs_addr);
  assign ex_conflict = rs_use && ex_hit;

  // Priority: x0, then EX, then WB, then register file.
  always_comb begin
    rs_data = rf_data;
    if (rs_zero) begin
      rs_data = '0;
    end else if (EX_BYPASS && ex_hit) begin
      rs_data = ex_data;
    end else if (wb_hit) begin
      rs_data = wb_data;
    end
  end

endmodule

// File: rtl/ex_issue.sv
// Registered issue stage between decode and the execute ALU.
// Define EX_FWD_EN to enable the EX->issue bypass; otherwise RAW on the EX
// producer stalls decode until it leaves the stage.
module ex_issue
  import core_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  output logic                      id_ready_o,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic                      rs1_use_i,
  input  logic                      rs2_use_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      rd_we_i,
  input  logic [1:0]                op_a_sel_i,
  input  logic [1:0]                op_b_sel_i,
  input  logic [OP_WIDTH-1:0]       alu_op_i,
  input  logic                      invert_i,
  input  logic [DATA_WIDTH-1:0]     ex_result_i,
  input  logic                      wb_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output logic [DATA_WIDTH-1:0]     operands_a_o,
  output logic [DATA_WIDTH-1:0]     operands_b_o,
  output logic [OP_WIDTH-1:0]       alu_op_o,
  output logic                      invert_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o
);

  localparam ex_bundle_t RESET_BUNDLE = '{
    op_a:    '0,
    op_b:    '0,
    alu_op:  ADD_SUB,
    invert:  1'b0,
    rd_addr: '0,
    rd_we:   1'b0
  };

  ex_bundle_t            ex_q;
  ex_bundle_t            ex_d;
  logic                  ex_we;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic                  rs1_conflict;
  logic                  rs2_conflict;
  logic                  hazard;
  logic                  capture;

`ifdef EX_FWD_EN
  localparam bit EX_BYPASS = 1'b1;
  logic unused_conflict;
  assign unused_conflict = rs1_conflict ^ rs2_conflict;
  assign hazard          = 1'b0;
`else
  localparam bit EX_BYPASS = 1'b0;
  assign hazard = rs1_conflict || rs2_conflict;
`endif

  assign ex_we      = ex_valid_o && ex_q.rd_we;
  assign id_ready_o = !rst_i && (!ex_valid_o || ex_ready_i) && !hazard;
  assign capture    = id_valid_i && id_ready_o && !flush_i;

  fwd_mux #(.EX_BYPASS(EX_BYPASS)) u_fwd_rs1 (
    .rs_addr     (rs1_addr_i),
    .rs_use      (rs1_use_i),
    .rf_data     (rs1_data_i),
    .ex_we       (ex_we),
    .ex_addr     (ex_q.rd_addr),
    .ex_data     (ex_result_i),
    .wb_we       (wb_we_i),
    .wb_addr     (wb_addr_i),
    .wb_data     (wb_data_i),
    .rs_data     (rs1_val),
    .ex_conflict (rs1_conflict)
  );

  fwd_mux #(.EX_BYPASS(EX_BYPASS)) u_fwd_rs2 (
    .rs_addr     (rs2_addr_i),
    .rs_use      (rs2_use_i),
    .rf_data     (rs2_data_i),
    .ex_we       (ex_we),
    .ex_addr     (ex_q.rd_addr),
    .ex_data     (ex_result_i),
    .wb_we       (wb_we_i),
    .wb_addr     (wb_addr_i),
    .wb_data     (wb_data_i),
    .rs_data     (rs2_val),
    .ex_conflict (rs2_conflict)
  );

  // Operand selection, ALU operand ordering and next bundle.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    unique case (op_a_sel_e'(op_a_sel_i))
      OPA_RS1: sel_a = rs1_val;
      OPA_PC:  sel_a = pc_i;
      default: sel_a = '0;
    endcase
    unique case (op_b_sel_e'(op_b_sel_i))
      OPB_RS2: sel_b = rs2_val;
      OPB_IMM: sel_b = imm_i;
      OPB_4:   sel_b = DATA_WIDTH'(4);
      default: sel_b = '0;
    endcase

    ex_d         = RESET_BUNDLE;
    ex_d.op_a    = needs_swap(alu_op_i) ? sel_b : sel_a;
    ex_d.op_b    = needs_swap(alu_op_i) ? sel_a : sel_b;
    ex_d.alu_op  = alu_op_i;
    ex_d.invert  = invert_i;
    ex_d.rd_addr = rd_addr_i;
    ex_d.rd_we   = rd_we_i && (rd_addr_i != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_o <= 1'b0;
      ex_q       <= RESET_BUNDLE;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (capture) begin
      ex_valid_o <= 1'b1;
      ex_q       <= ex_d;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

  assign operands_a_o = ex_q.op_a;
  assign operands_b_o = ex_q.op_b;
  assign alu_op_o     = ex_q.alu_op;
  assign invert_o     = ex_q.invert;
  assign rd_addr_o    = ex_q.rd_addr;
  assign rd_we_o      = ex_q.rd_we;

endmodule
